// File: rtl/spi3w_pkg.sv
// Shared constants, state encoding and helpers for the 3-wire SPI responder.
// Header layout: R/W flag, two-bit byte-count field, then the register address.
package spi3w_pkg;

    localparam int unsigned RW_BIT   = 15;
    localparam int unsigned W_MSB    = 14;
    localparam int unsigned W_LSB    = 13;
    localparam int unsigned HDR_LEN  = 16;
    localparam int unsigned DATA_LEN = 8;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StWdata,
        StRdata,
        StDone
    } spi_state_e;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/spi3w_edge_sync.sv
// Brings the asynchronous SPI pins into clk_20m and flags sclk edges.
// Edges are taken from the last synchronizer stage and one extra history flop.
module spi3w_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_20m,
    input  logic rstn,
    input  logic sclk,
    input  logic cs_n,
    input  logic sdio,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_n_sync,
    output logic sdio_sync
);

    logic [SYNC_STAGES:0]   sclk_q;
    logic [SYNC_STAGES-1:0] cs_n_q;
    logic [SYNC_STAGES-1:0] sdio_q;

    always_ff @(posedge clk_20m) begin
        if (!rstn) begin
            sclk_q <= '0;
            cs_n_q <= '1;
            sdio_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
            cs_n_q <= {cs_n_q[SYNC_STAGES-2:0], cs_n};
            sdio_q <= {sdio_q[SYNC_STAGES-2:0], sdio};
        end
    end

    always_comb begin
        sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
        sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
        cs_n_sync = cs_n_q[SYNC_STAGES-1];
        sdio_sync = sdio_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/spi3w_slave_regfile.sv
// 3-wire SPI responder with a DEPTH x 8 flop register file, a fabric read port
// and a write-notify strobe. Frames are 16-bit header + 8-bit data, MSB first, CPOL 0.
module spi3w_slave_regfile
    import spi3w_pkg::*;
#(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_20m,
    input  logic              rstn,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              sdio_i,
    output logic              sdio_o,
    output logic              sdio_oe,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frame_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_n_s;
    logic sdio_s;

    spi3w_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_20m  (clk_20m),
        .rstn     (rstn),
        .sclk     (spi_sclk),
        .cs_n     (spi_cs_n),
        .sdio     (sdio_i),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .cs_n_sync(cs_n_s),
        .sdio_sync(sdio_s)
    );

    spi_state_e           state_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [HDR_LEN-2:0]   shift_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_LEN-1:0]  rd_sh_q;
    logic [DATA_LEN-1:0]  regs_q [DEPTH];

    logic [ADDR_W-1:0]    hdr_addr;
    logic [DATA_LEN-1:0]  wdata_byte;
    logic [DATA_LEN-1:0]  spi_rd_val;
    logic                 active;

    // shift_q holds the 15 bits seen before the current rise; the new bit completes the field
    always_comb begin
        hdr_addr   = {shift_q[W_LSB-2:0], sdio_s};
        wdata_byte = {shift_q[DATA_LEN-2:0], sdio_s};
        spi_rd_val = addr_in_range(32'(addr_q), DEPTH) ? regs_q[addr_q[IDX_W-1:0]] : '0;
        active     = (state_q == StHdr) || (state_q == StWdata) || (state_q == StRdata);
    end

    always_ff @(posedge clk_20m) begin
        if (!rstn) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            rd_sh_q   <= '0;
            sdio_o    <= 1'b0;
            sdio_oe   <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            // A deselect mid-frame wins over any coincident sclk edge
            if (active && cs_n_s) begin
                state_q   <= StIdle;
                bit_cnt_q <= '0;
                sdio_o    <= 1'b0;
                sdio_oe   <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (!cs_n_s) begin
                            state_q   <= StHdr;
                            bit_cnt_q <= '0;
                        end
                    end
                    StHdr: begin
                        if (sclk_rise) begin
                            shift_q <= {shift_q[HDR_LEN-3:0], sdio_s};
                            if (bit_cnt_q == CNT_W'(HDR_LEN - 1)) begin
                                bit_cnt_q <= '0;
                                addr_q    <= hdr_addr;
                                state_q   <= shift_q[RW_BIT-1] ? StRdata : StWdata;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    StWdata: begin
                        if (sclk_rise) begin
                            shift_q <= {shift_q[HDR_LEN-3:0], sdio_s};
                            if (bit_cnt_q == CNT_W'(DATA_LEN - 1)) begin
                                bit_cnt_q <= '0;
                                state_q   <= StDone;
                                if (addr_in_range(32'(addr_q), DEPTH)) begin
                                    regs_q[addr_q[IDX_W-1:0]] <= wdata_byte;
                                    wr_valid <= 1'b1;
                                    wr_addr  <= addr_q;
                                    wr_data  <= wdata_byte;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    StRdata: begin
                        if (sclk_fall) begin
                            if (bit_cnt_q == '0) begin
                                sdio_o    <= spi_rd_val[DATA_LEN-1];
                                rd_sh_q   <= {spi_rd_val[DATA_LEN-2:0], 1'b0};
                                sdio_oe   <= 1'b1;
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end else if (bit_cnt_q == CNT_W'(DATA_LEN)) begin
                                sdio_o    <= 1'b0;
                                sdio_oe   <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= StDone;
                            end else begin
                                sdio_o    <= rd_sh_q[DATA_LEN-1];
                                rd_sh_q   <= {rd_sh_q[DATA_LEN-2:0], 1'b0};
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    StDone: begin
                        if (cs_n_s) begin
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // Same-cycle SPI write to rd_addr returns the pre-write value
    always_ff @(posedge clk_20m) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (addr_in_range(32'(rd_addr), DEPTH)) begin
            rd_data <= regs_q[rd_addr[IDX_W-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_spi3w_slave_regfile.sv
// Bench for spi3w_slave_regfile: a bit-banged SPI master with a shared SDIO line,
// a write scoreboard fed by the stimulus, a frame table and a few corner sequences.
module tb_spi3w_slave_regfile;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DEPTH  = 64;
    localparam int          HALF   = 5;

    logic              clk_20m = 1'b0;
    logic              rstn = 1'b0;
    logic              spi_sclk = 1'b0;
    logic              spi_cs_n = 1'b1;
    logic              sdio_m = 1'b0;
    logic              sdio_line;
    logic              sdio_o;
    logic              sdio_oe;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
    logic              frame_err;

    assign sdio_line = sdio_oe ? sdio_o : sdio_m;

    always #25 clk_20m = ~clk_20m;

    spi3w_slave_regfile #(
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .SYNC_STAGES(2)
    ) dut (
        .clk_20m  (clk_20m),
        .rstn     (rstn),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .sdio_i   (sdio_line),
        .sdio_o   (sdio_o),
        .sdio_oe  (sdio_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .frame_err(frame_err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
        logic              exp_wr;
        logic [7:0]        exp_rd;
    } vec_t;

    int         n_chk = 0;
    int         n_pass = 0;
    int         n_ferr = 0;
    wr_t        wr_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] model [DEPTH];
    vec_t       vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk_20m);
        #1;
    endtask

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        wr_q.push_back(e);
        model[a[5:0]] = d;
    endtask

    // Shifts nbits of 'bits' MSB first; samples the shared line before rises rd_from..rd_from+7
    task automatic spi_xfer(input logic [31:0] bits, input int nbits, input int rd_from,
                            output logic [7:0] rbyte, output int oe_hi);
        rbyte = '0;
        oe_hi = 0;
        spi_cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            sdio_m = bits[nbits-1-i];
            wait_clk(HALF);
            if (i >= rd_from && i < rd_from + 8) begin
                rbyte = {rbyte[6:0], sdio_line};
                if (sdio_oe) oe_hi++;
            end
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        wait_clk(HALF);
    endtask

    task automatic end_frame();
        spi_cs_n = 1'b1;
        sdio_m   = 1'b0;
        wait_clk(4 * HALF);
    endtask

    task automatic fab_chk(input logic [ADDR_W-1:0] a);
        logic [7:0] e;
        e = (a < ADDR_W'(DEPTH)) ? model[a[5:0]] : 8'h00;
        rd_addr = a;
        wait_clk(2);
        chk($sformatf("rd_data@%03h", a), {24'h0, rd_data}, {24'h0, e});
    endtask

    // Scoreboard: every wr_valid must match the oldest expected write
    always @(negedge clk_20m) begin
        if (rstn && wr_valid) begin
            if (wr_q.size() == 0) begin
                n_chk++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected no write",
                         wr_addr, wr_data);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", {19'h0, wr_addr}, {19'h0, e.a});
                chk("wr_data", {24'h0, wr_data}, {24'h0, e.d});
            end
        end
        if (rstn && frame_err) n_ferr++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int         oe;
        int         ferr0;

        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        vt[0]  = '{1'b0, 13'h010, 8'hA5, 1'b1, 8'h00};
        vt[1]  = '{1'b1, 13'h010, 8'h00, 1'b0, 8'hA5};
        vt[2]  = '{1'b1, 13'h100, 8'h00, 1'b0, 8'h00};
        vt[3]  = '{1'b0, 13'h100, 8'h77, 1'b0, 8'h00};
        vt[4]  = '{1'b1, 13'h000, 8'h00, 1'b0, 8'h00};
        vt[5]  = '{1'b0, 13'h001, 8'h11, 1'b1, 8'h00};
        vt[6]  = '{1'b0, 13'h002, 8'h22, 1'b1, 8'h00};
        vt[7]  = '{1'b1, 13'h001, 8'h00, 1'b0, 8'h11};
        vt[8]  = '{1'b1, 13'h002, 8'h00, 1'b0, 8'h22};
        vt[9]  = '{1'b0, 13'h03F, 8'h5C, 1'b1, 8'h00};
        vt[10] = '{1'b1, 13'h03F, 8'h00, 1'b0, 8'h5C};
        vt[11] = '{1'b1, 13'h040, 8'h00, 1'b0, 8'h00};

        // Reset values
        wait_clk(4);
        chk("rst_sdio_o", {31'h0, sdio_o}, 32'h0);
        chk("rst_sdio_oe", {31'h0, sdio_oe}, 32'h0);
        chk("rst_wr_valid", {31'h0, wr_valid}, 32'h0);
        chk("rst_wr_addr", {19'h0, wr_addr}, 32'h0);
        chk("rst_wr_data", {24'h0, wr_data}, 32'h0);
        chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
        rstn = 1'b1;
        wait_clk(4);

        // Frame table
        for (int k = 0; k < 12; k++) begin
            if (!vt[k].rw) begin
                if (vt[k].exp_wr) push_wr(vt[k].addr, vt[k].data);
                spi_xfer({8'h00, 3'b000, vt[k].addr, vt[k].data}, 24, 99, rb, oe);
                end_frame();
                fab_chk(vt[k].addr);
            end else begin
                rd_q.push_back(vt[k].exp_rd);
                spi_xfer({8'h00, 3'b100, vt[k].addr, 8'h00}, 24, 16, rb, oe);
                chk($sformatf("oe_low_after_bit0[%0d]", k), {31'h0, sdio_oe}, 32'h0);
                end_frame();
                chk($sformatf("spi_rd_byte[%0d]", k), {24'h0, rb}, {24'h0, rd_q.pop_front()});
                chk($sformatf("oe_bit_times[%0d]", k), oe, 8);
            end
        end
        chk("no_frame_err_in_table", n_ferr, 0);
        foreach (vt[k]) fab_chk(vt[k].addr);

        // Abort after 20 bits of write 0x00055A, then a normal frame
        ferr0 = n_ferr;
        spi_xfer(32'h0000_055A >> 4, 20, 99, rb, oe);
        end_frame();
        chk("abort_frame_err_pulses", n_ferr, ferr0 + 1);
        fab_chk(13'h005);
        push_wr(13'h005, 8'h3C);
        spi_xfer(32'h0000_053C, 24, 99, rb, oe);
        end_frame();
        fab_chk(13'h005);
        chk("after_abort_frame_err", n_ferr, ferr0 + 1);

        // W1:W0 = 11 is a single-byte write; trailing bits are ignored
        push_wr(13'h006, 8'h99);
        spi_xfer(32'h6006_99FF, 32, 99, rb, oe);
        chk("wfield_no_drive", {31'h0, sdio_oe}, 32'h0);
        end_frame();
        fab_chk(13'h006);
        fab_chk(13'h007);

        // rstn low while the responder is driving read data
        spi_xfer(32'h0000_8010, 16, 99, rb, oe);
        chk("rdata_oe_high", {31'h0, sdio_oe}, 32'h1);
        rstn = 1'b0;
        wait_clk(1);
        chk("rst_mid_read_oe", {31'h0, sdio_oe}, 32'h0);
        spi_cs_n = 1'b1;
        wait_clk(3);
        rstn = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        wait_clk(2 * HALF);
        fab_chk(13'h010);
        fab_chk(13'h005);

        // Recovery after reset: write then read back over SPI
        push_wr(13'h010, 8'h5A);
        spi_xfer(32'h0000_105A, 24, 99, rb, oe);
        end_frame();
        spi_xfer(32'h0080_1000, 24, 16, rb, oe);
        end_frame();
        chk("post_reset_spi_rd", {24'h0, rb}, 32'h5A);

        wait_clk(4);
        chk("wr_queue_drained", wr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
